// File: rtl/trap_pkg.sv
// Shared definitions for the trap sequencer: cause codes, FSM encoding and default handler vector.
package trap_pkg;

  localparam logic [31:0] CAUSE_INT   = 32'h00;
  localparam logic [31:0] CAUSE_SYS   = 32'h20;
  localparam logic [31:0] CAUSE_BRK   = 32'h24;
  localparam logic [31:0] CAUSE_UNDEF = 32'h28;
  localparam logic [31:0] CAUSE_OVF   = 32'h30;

  localparam logic [31:0] HANDLER_VEC_DEF = 32'h0000_0080;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_ENTER   = 3'd2,
    ST_HANDLER = 3'd3,
    ST_RETURN  = 3'd4,
    ST_HALT    = 3'd5
  } trap_state_t;

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline-side bundle of the trap sequencer: exception flags and PCs in, pipeline control out.
import trap_pkg::*;

interface trap_sequencer_if #(
  parameter int NUM_IRQ = 4
);
  // instr_valid and redirect_valid are valid-only qualifiers: there is no ready; the
  // receiver must consume the qualified payload in the cycle the valid is high.
  logic [NUM_IRQ-1:0] irq;
  logic               irq_mask_we;
  logic [NUM_IRQ-1:0] irq_mask_wdata;
  logic               instr_valid;
  logic               syscall;
  logic               brk;
  logic               div_by_zero;
  logic               undef_instr;
  logic               overflow;
  logic               eret;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;

  logic               trap_take;
  logic               flush;
  logic               stall;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic [31:0]        cause_out;
  logic [31:0]        epc_out;
  logic               in_handler;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               halted;
  trap_state_t        state_dbg;

  modport master (
    output irq, irq_mask_we, irq_mask_wdata, instr_valid, syscall, brk, div_by_zero,
           undef_instr, overflow, eret, pc, pc_plus4,
    input  trap_take, flush, stall, redirect_valid, redirect_pc, cause_out, epc_out,
           in_handler, irq_pending, halted, state_dbg
  );

  modport slave (
    input  irq, irq_mask_we, irq_mask_wdata, instr_valid, syscall, brk, div_by_zero,
           undef_instr, overflow, eret, pc, pc_plus4,
    output trap_take, flush, stall, redirect_valid, redirect_pc, cause_out, epc_out,
           in_handler, irq_pending, halted, state_dbg
  );

endinterface

// File: rtl/trap_priority_enc.sv
// Picks the single highest-priority trap source for a valid instruction in IDLE.
import trap_pkg::*;

module trap_priority_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic               instr_valid,
  input  logic               idle,
  input  logic [NUM_IRQ-1:0] int_masked,
  input  logic               syscall,
  input  logic               brk,
  input  logic               div_by_zero,
  input  logic               undef_instr,
  input  logic               overflow,
  output logic               take,
  output logic               is_int,
  output logic               epc_sel_next,
  output logic [31:0]        cause
);

  always_comb begin
    take         = 1'b0;
    is_int       = 1'b0;
    epc_sel_next = 1'b0;
    cause        = 32'h0;
    if (instr_valid && idle) begin
      if (|int_masked) begin
        // Interrupts resume after the current instruction, so EPC is pc+4.
        take         = 1'b1;
        is_int       = 1'b1;
        epc_sel_next = 1'b1;
        cause        = CAUSE_INT | (32'(int_masked) << 8);
      end else if (syscall) begin
        take  = 1'b1;
        cause = CAUSE_SYS;
      end else if (brk || div_by_zero) begin
        take  = 1'b1;
        cause = CAUSE_BRK;
      end else if (undef_instr) begin
        take  = 1'b1;
        cause = CAUSE_UNDEF;
      end else if (overflow) begin
        take  = 1'b1;
        cause = CAUSE_OVF;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: latches cause/EPC, flushes, redirects to the handler and back.
import trap_pkg::*;

module trap_sequencer #(
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] HANDLER_VEC  = HANDLER_VEC_DEF,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  trap_sequencer_if.slave         bus
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  trap_state_t        state_q, state_d;
  logic [3:0]         cnt_q;
  logic [NUM_IRQ-1:0] mask_q, pend_q, int_masked;
  logic [31:0]        cause_q, epc_q, enc_cause;
  logic               take_q, enc_take, enc_is_int, enc_epc_next, sync_exc;

  assign int_masked = pend_q & mask_q;
  assign sync_exc   = bus.instr_valid & (bus.syscall | bus.brk | bus.div_by_zero |
                                         bus.undef_instr | bus.overflow);

  trap_priority_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .instr_valid  (bus.instr_valid),
    .idle         (state_q == ST_IDLE),
    .int_masked   (int_masked),
    .syscall      (bus.syscall),
    .brk          (bus.brk),
    .div_by_zero  (bus.div_by_zero),
    .undef_instr  (bus.undef_instr),
    .overflow     (bus.overflow),
    .take         (enc_take),
    .is_int       (enc_is_int),
    .epc_sel_next (enc_epc_next),
    .cause        (enc_cause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mask_q  <= '1;
      pend_q  <= '0;
      cause_q <= 32'h0;
      epc_q   <= 32'h0;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      take_q  <= enc_take;
      if (bus.irq_mask_we) mask_q <= bus.irq_mask_wdata;
      // New requests win over the clear caused by taking an interrupt.
      pend_q  <= (enc_is_int ? '0 : pend_q) | bus.irq;
      if (enc_take) begin
        cause_q <= enc_cause;
        epc_q   <= enc_epc_next ? bus.pc_plus4 : bus.pc;
        cnt_q   <= FLUSH_INIT;
      end else if (state_q == ST_FLUSH && cnt_q != 4'd0) begin
        cnt_q   <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.flush          = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.in_handler     = 1'b0;
    bus.halted         = 1'b0;
    unique case (state_q)
      ST_IDLE: if (enc_take) state_d = ST_FLUSH;
      ST_FLUSH: begin
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_ENTER;
      end
      ST_ENTER: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = HANDLER_VEC;
        bus.in_handler     = 1'b1;
        state_d            = ST_HANDLER;
      end
      ST_HANDLER: begin
        bus.in_handler = 1'b1;
        // A fault inside the handler is a double fault; eret is ignored then.
        if (sync_exc) state_d = ST_HALT;
        else if (bus.eret && bus.instr_valid) state_d = ST_RETURN;
      end
      ST_RETURN: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = epc_q;
        bus.flush          = 1'b1;
        bus.in_handler     = 1'b1;
        state_d            = ST_IDLE;
      end
      ST_HALT: begin
        bus.halted     = 1'b1;
        bus.stall      = 1'b1;
        bus.flush      = 1'b1;
        bus.in_handler = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.trap_take   = take_q;
  assign bus.cause_out   = cause_q;
  assign bus.epc_out     = epc_q;
  assign bus.irq_pending = pend_q;
  assign bus.state_dbg   = state_q;

endmodule
